mem_wb_stage: RTL
=================

# mem_wb_stage

Back end of the pipeline: takes one decoded instruction per handshake from the EX/MEM boundary, performs its data-memory access (LW/LB/SW/SB) over a req/ack bus, and drives the register-file write port consumed by the decode stage (`reg_write`, `write_reg`, `write_data`). It is the writer side of the decode stage's register write interface and the initiator of the data-memory bus. Non-memory instructions pass through in one cycle. Memory instructions stall upstream until acknowledged or timed out.

## Interface
- `ACK_TIMEOUT`, 64: maximum cycles `mem_req` is held without `mem_ack`; must be ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream slot holds an instruction.
- `in_ready`  out  1  block accepts this cycle. Transfer occurs when `in_valid && in_ready`.
- `op`  in  6  opcode (`ins[31:26]`).
- `if_reg_write`  in  1  instruction writes a register.
- `if_mem_read`  in  1  load.
- `if_mem_write`  in  1  store.
- `alu_result`  in  32  effective address (mem ops) or result (others).
- `store_data`  in  32  rt value for stores.
- `data_write_reg`  in  5  destination register.
- `npc`  in  32  link value for JAL.
- `mem_req`  out  1  memory request pending.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  32  word-aligned address `{alu_result[31:2],2'b00}`.
- `mem_wdata`  out  32  write data.
- `mem_be`  out  4  byte enables, little-endian lanes.
- `mem_ack`  in  1  request completed; `mem_rdata` valid the same cycle.
- `mem_rdata`  in  32  read data.
- `reg_write`  out  1  one-cycle register write strobe.
- `write_reg`  out  5  destination register.
- `write_data`  out  32  value to write.
- `mem_err`  out  1  sticky flag: a request timed out.

## Operation
- FSM has two states, IDLE and MEM. `in_ready` = (state==IDLE).
- IDLE, non-mem accept (`!if_mem_read && !if_mem_write`):
  - Stay in IDLE.
  - Next cycle `reg_write` = `if_reg_write && data_write_reg!=0`.
  - `write_data` = `npc` if `op==6'b000011` (JAL), else `alu_result`.
- IDLE, mem accept: latch address, lane (`alu_result[1:0]`), op, rd and kind. Go to MEM.
- MEM: hold `mem_req`=1 with stable `mem_addr`/`mem_we`/`mem_wdata`/`mem_be` until ack.
- On `mem_ack`, return to IDLE.
  - Load: capture data. Next cycle pulse `reg_write` if rd≠0.
  - LW (`100011`): `write_data` = `mem_rdata`.
  - LB (`100000`): lane k = addr[1:0], byte = `mem_rdata[8k+7:8k]`, sign-extended to 32.
  - Store: no register write.
- Stores:
  - SW (`101011`): `mem_be`=4'b1111, `mem_wdata`=`store_data`.
  - SB (`101000`): `mem_be`=1<<addr[1:0], `mem_wdata`={4{store_data[7:0]}}.
  - LW, LB: `mem_we`=0, `mem_be`=4'b1111.
- Misaligned LW/SW: `addr[1:0]` is ignored; the access is treated as aligned.
- `if_mem_read && if_mem_write` both set: treated as a store; no register write.
- Timeout counter (width clog2(ACK_TIMEOUT+1)):
  - Clears on entry to MEM and increments each MEM cycle without ack.
  - When it reaches ACK_TIMEOUT: drop the request, set `mem_err`, discard the instruction (no write), return to IDLE.
- `mem_ack` arriving in the final timeout cycle wins: normal completion, no error.
- `mem_ack` while in IDLE is ignored.
- `mem_err` clears only on reset.

## Timing
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0, except `in_ready`=1.
  - Pending request is abandoned and no write occurs.
- Non-mem accept at cycle N: `reg_write` high in cycle N+1 only. Back-to-back accepts give one write per cycle.
- Mem accept at N: `mem_req` high from N+1.
- Ack sampled at cycle M ≥ N+1:
  - `mem_req`=0 and `in_ready`=1 at M+1.
  - Load `reg_write` high at M+1 only.
  - Minimum load latency is accept+2.
- Timeout: `mem_req` high for cycles N+1..N+ACK_TIMEOUT. At N+ACK_TIMEOUT+1: `mem_req`=0, `mem_err`=1, `in_ready`=1.
- `write_reg`/`write_data` are registered. They are valid whenever `reg_write`=1 and hold their last value otherwise.

## Test plan
- Reset, then accept non-mem with `if_reg_write`=1, rd=5, `alu_result`=0x1234 -> next cycle `reg_write`=1, `write_reg`=5, `write_data`=0x1234; following cycle `reg_write`=0.
- JAL (`op`=000011, rd=31, `npc`=0x0040_0008), then ALU op rd=0 on the next cycle -> one write of 0x0040_0008 to r31; no strobe for r0.
- LB `alu_result`=0x103, ack 2 cycles after `mem_req` with `mem_rdata`=0x80FF_0000 -> `mem_addr`=0x100, `mem_be`=1111, `write_data`=0xFFFF_FF80; `in_ready` low throughout MEM.
- SB addr 0x202, `store_data`=0xAB -> `mem_we`=1, `mem_be`=0100, `mem_wdata`=0xABAB_ABAB; no `reg_write`.
- `ACK_TIMEOUT`=4, LW, no ack -> `mem_req` high exactly 4 cycles, then `mem_err`=1 (sticky) and no write. Repeat with ack in the 4th cycle -> normal write, `mem_err` unchanged.
- Assert `rst_n` low mid-MEM -> `mem_req` drops immediately; after release, state is IDLE, no `reg_write`, `mem_err`=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: runs one LW/LB/SW/SB per handshake over a req/ack bus
// and drives the register-file write port; non-memory instructions retire in one cycle.
module mem_wb_stage #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  op,
    input  logic        if_reg_write,
    input  logic        if_mem_read,
    input  logic        if_mem_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  data_write_reg,
    input  logic [31:0] npc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        mem_err
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_t;

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // the bus request is held stable until the first cycle mem_ack is seen high.
    state_t       state;
    state_t       state_next;
    logic [CW-1:0] cnt;
    logic [1:0]   lane;
    logic         lat_lb;
    logic [4:0]   lat_rd;
    logic         accept;
    logic         is_mem;
    logic         timeout;
    logic [7:0]   byte_sel;
    logic [31:0]  load_data;

    assign in_ready = (state == IDLE);
    assign mem_req  = (state == MEM);
    assign accept   = in_valid && in_ready;
    assign is_mem   = if_mem_read || if_mem_write;
    // An ack in the last allowed cycle completes normally rather than timing out.
    assign timeout  = (state == MEM) && !mem_ack && (cnt == CW'(ACK_TIMEOUT - 1));

    assign byte_sel  = mem_rdata[{lane, 3'b000} +: 8];
    assign load_data = lat_lb ? {{24{byte_sel[7]}}, byte_sel} : mem_rdata;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mem) state_next = MEM;
            MEM:  if (mem_ack || timeout) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept && is_mem)
                cnt <= '0;
            else if (state == MEM && !mem_ack)
                cnt <= cnt + 1'b1;
        end
    end

    // Request attributes are captured once at accept so the bus sees them stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_be    <= '0;
            lane      <= '0;
            lat_lb    <= 1'b0;
            lat_rd    <= '0;
        end else if (accept && is_mem) begin
            mem_addr <= {alu_result[31:2], 2'b00};
            mem_we   <= if_mem_write;
            lane     <= alu_result[1:0];
            lat_lb   <= (op == OP_LB);
            lat_rd   <= data_write_reg;
            if (if_mem_write && op == OP_SB) begin
                mem_be    <= 4'b0001 << alu_result[1:0];
                mem_wdata <= {4{store_data[7:0]}};
            end else if (if_mem_write) begin
                mem_be    <= 4'b1111;
                mem_wdata <= store_data;
            end else begin
                mem_be    <= 4'b1111;
                mem_wdata <= '0;
            end
        end
    end

    // write_reg/write_data only change alongside a strobe and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            mem_err    <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            if (accept && !is_mem && if_reg_write && data_write_reg != 5'd0) begin
                reg_write  <= 1'b1;
                write_reg  <= data_write_reg;
                write_data <= (op == OP_JAL) ? npc : alu_result;
            end else if (state == MEM && mem_ack && !mem_we && lat_rd != 5'd0) begin
                reg_write  <= 1'b1;
                write_reg  <= lat_rd;
                write_data <= load_data;
            end
            if (timeout)
                mem_err <= 1'b1;
        end
    end
endmodule
